ahb_lite_sram_slave: RTL and testbench

- AHB-Lite slave wrapping an on-chip word-organised SRAM.
- Sits directly downstream of the team's AHB-Lite bus interface and implements its dut-side signal set: it consumes address/control/write data and produces HRDATA, HREADYOUT and HRESP.
- Adds programmable wait states and two-cycle ERROR responses, and is the reference slave the bench driver and monitor run against.

---
 rtl/ahb_lite_sram_slave_if.sv | 30 +++
 rtl/ahb_lite_sram_slave.sv | 131 +++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite slave-side signal bundle for the on-chip SRAM slave.
// Handshake: a transfer is offered when HSEL & HTRANS[1] and accepted at the edge where HREADY=1;
// its data phase ends at the first edge with HREADYOUT=1, with HRESP qualifying that completion.
interface ahb_lite_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of a word-organised SRAM, with programmable wait states
// and two-cycle ERROR responses for out-of-range or misaligned transfers.
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_lite_sram_slave_if.slave bus,
  output logic [2:0]           o_dbg_state
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LP_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  state_e                r_state;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic                  r_write;
  logic [IDX_W-1:0]      r_idx;
  logic [3:0]            r_strb;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic       w_accept;
  logic       w_err;
  logic       w_commit;
  logic [3:0] w_strb;
  logic       w_unused;

  assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};

  // New transfers are only taken while the slave is not stalling its own data phase.
  assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] &
                    ((r_state == S_IDLE) | (r_state == S_DATA) | (r_state == S_ERR2));

  assign w_err = ({1'b0, bus.HADDR} >= LP_BYTES) |
                 (bus.HSIZE > 3'd2) |
                 ((bus.HSIZE == 3'd1) & bus.HADDR[0]) |
                 ((bus.HSIZE == 3'd2) & (|bus.HADDR[1:0]));

  always_comb begin
    w_strb = 4'b1111;
    case (bus.HSIZE)
      3'd0:    w_strb = 4'b0001 << bus.HADDR[1:0];
      3'd1:    w_strb = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_strb      <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          if (w_accept) begin
            r_write <= bus.HWRITE;
            r_idx   <= bus.HADDR[IDX_W+1:2];
            r_strb  <= w_strb;
            if (w_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              r_state     <= S_WAIT;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
              r_cnt       <= 4'(WAIT_STATES);
            end else begin
              r_state     <= S_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Write data arrives in the data phase, so the lanes commit at the edge closing DATA.
  assign w_commit = (r_state == S_DATA) & r_write;

  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_strb[i]) r_mem[r_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HRDATA    = ((r_state == S_DATA) && !r_write) ? r_mem[r_idx] : '0;
  assign bus.HREADYOUT = r_hreadyout;
  assign bus.HRESP     = r_hresp;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: three instances (0, 3 and 4 wait states) on one shared master,
// a byte-addressed transfer model checked every cycle, and directed literal expectations.
module tb_ahb_lite_sram_slave;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared master signals ----------------
  logic        hsel, hwrite, force_nrdy, chk_en;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [1:0]  active;
  logic        bus_hready;

  logic        ro_v   [3];
  logic        resp_v [3];
  logic [31:0] rd_v   [3];
  logic [2:0]  unused_st_v [3];

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 4);
    ahb_lite_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.HSEL   = hsel & (active == g);
    assign bus.HADDR  = haddr;
    assign bus.HWDATA = hwdata;
    assign bus.HWRITE = hwrite;
    assign bus.HSIZE  = hsize;
    assign bus.HBURST = hburst;
    assign bus.HPROT  = hprot;
    assign bus.HTRANS = htrans;
    assign bus.HREADY = bus_hready;
    assign ro_v[g]    = bus.HREADYOUT;
    assign resp_v[g]  = bus.HRESP;
    assign rd_v[g]    = bus.HRDATA;
    ahb_lite_sram_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(WS)
    ) dut (
      .HCLK(clk), .HRESETn(rst_n), .bus(bus), .o_dbg_state(unused_st_v[g])
    );
  end

  assign bus_hready = ro_v[active] & ~force_nrdy;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------- transfer-level model ----------------
  typedef struct {
    bit ro;
    bit resp;
    bit rd;
    bit wr;
    int addr;
    int size;
  } ent_t;

  ent_t       q[$];
  ent_t       cur;
  logic [7:0] mem_b [0:1023];

  function automatic ent_t mk(bit ro, bit resp, bit rd, bit wr, int addr, int size);
    ent_t e;
    e.ro = ro; e.resp = resp; e.rd = rd; e.wr = wr; e.addr = addr; e.size = size;
    return e;
  endfunction

  function automatic int ws_of(logic [1:0] a);
    return (a == 2'd0) ? 0 : ((a == 2'd1) ? 3 : 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit acc, bad;
    if (!rst_n) begin
      q.delete();
      cur = mk(1, 0, 0, 0, 0, 0);
    end else begin
      if (cur.wr)
        for (int k = 0; k < (1 << cur.size); k++)
          mem_b[cur.addr + k] = hwdata[8*((cur.addr + k) % 4) +: 8];
      acc = hsel && cur.ro && !force_nrdy && htrans[1];
      if (q.size() > 0) begin
        cur = q.pop_front();
      end else if (acc) begin
        bad = (haddr >= 32'd1024) || (hsize > 3'd2) || ((haddr % (32'd1 << hsize)) != 0);
        if (bad) begin
          q.push_back(mk(0, 1, 0, 0, 0, 0));
          q.push_back(mk(1, 1, 0, 0, 0, 0));
        end else begin
          for (int i = 0; i < ws_of(active); i++) q.push_back(mk(0, 0, 0, 0, 0, 0));
          q.push_back(mk(1, 0, !hwrite, hwrite, int'(haddr), int'(hsize)));
        end
        cur = q.pop_front();
      end else begin
        cur = mk(1, 0, 0, 0, 0, 0);
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] e;
    int          b;
    if (chk_en) begin
      b = cur.addr & ~3;
      e = cur.rd ? {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]} : 32'h0;
      chk1("cyc_hreadyout", ro_v[active], cur.ro);
      chk1("cyc_hresp", resp_v[active], cur.resp);
      chk("cyc_hrdata", rd_v[active], e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic addr_ph(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hsel = 1'b1; hwrite = wr; haddr = a; hsize = sz; htrans = 2'b10;
  endtask

  task automatic wait_ready(input string tag, output logic [31:0] rd, output logic resp,
                            output int waits);
    logic r;
    bit   done;
    waits = 0;
    done  = 0;
    rd    = '0;
    resp  = 1'b0;
    while (!done) begin
      @(negedge clk);
      r    = bus_hready;
      rd   = rd_v[active];
      resp = resp_v[active];
      @(posedge clk);
      #1;
      if (r) begin
        done = 1;
      end else begin
        waits++;
        if (waits > 40) begin
          n_chk++;
          n_err++;
          $display("FAIL %s_timeout: got no HREADY after %0d cycles, required completion", tag, waits);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic resp,
                      output int waits);
    logic [31:0] d0;
    logic        r0;
    int          w0;
    addr_ph(wr, a, sz);
    wait_ready("addr", d0, r0, w0);
    idle_bus();
    hwdata = wr ? wd : 32'h0;
    wait_ready("data", rd, resp, waits);
  endtask

  task automatic two_xfers(input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                           input logic w2, input logic [31:0] a2, input logic [31:0] d2,
                           output logic [31:0] rd1, output int wt1,
                           output logic [31:0] rd2, output int wt2);
    logic [31:0] dx;
    logic        rx;
    int          wx;
    addr_ph(w1, a1, 3'd2);
    wait_ready("p_addr", dx, rx, wx);
    addr_ph(w2, a2, 3'd2);
    hwdata = w1 ? d1 : 32'h0;
    wait_ready("p_data1", rd1, rx, wt1);
    idle_bus();
    hwdata = w2 ? d2 : 32'h0;
    wait_ready("p_data2", rd2, rx, wt2);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin : main
    logic [31:0] rd, rd2;
    logic        resp;
    int          wt, wt2;

    rst_n = 1'b0; hsel = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0; hsize = 3'd2;
    hburst = 3'd1; hprot = 4'b0011; htrans = 2'b00; force_nrdy = 1'b0; active = 2'd0;
    chk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_hreadyout", ro_v[0], 1'b1);
    chk1("reset_hresp", resp_v[0], 1'b0);
    chk("reset_hrdata", rd_v[0], 32'h0);
    chk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero wait states: back-to-back write then read of the same word.
    two_xfers(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h10, 32'h0, rd, wt, rd2, wt2);
    chk("ws0_write_waits", wt, 0);
    chk("ws0_read_data", rd2, 32'hDEADBEEF);
    chk("ws0_read_waits", wt2, 0);

    // Byte and halfword merges into an existing word.
    xfer(1'b1, 32'h20, 3'd2, 32'h11223344, rd, resp, wt);
    xfer(1'b1, 32'h21, 3'd0, 32'h0000AA00, rd, resp, wt);
    xfer(1'b1, 32'h22, 3'd1, 32'h55660000, rd, resp, wt);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, resp, wt);
    chk("merge_read_data", rd, 32'h5566AA44);
    chk1("merge_read_resp", resp, 1'b0);

    // Error responses leave memory untouched.
    xfer(1'b1, 32'h00, 3'd2, 32'hA5A5A5A5, rd, resp, wt);
    xfer(1'b1, 32'h40, 3'd2, 32'h0BADF00D, rd, resp, wt);
    xfer(1'b0, 32'h400, 3'd2, 32'h0, rd, resp, wt);
    chk1("err_range_resp", resp, 1'b1);
    chk("err_range_waits", wt, 1);
    xfer(1'b1, 32'h02, 3'd2, 32'hFFFFFFFF, rd, resp, wt);
    chk1("err_align_resp", resp, 1'b1);
    chk("err_align_waits", wt, 1);
    xfer(1'b1, 32'h40, 3'd3, 32'hFFFFFFFF, rd, resp, wt);
    chk1("err_size_resp", resp, 1'b1);
    xfer(1'b0, 32'h00, 3'd2, 32'h0, rd, resp, wt);
    chk("err_readback_00", rd, 32'hA5A5A5A5);
    xfer(1'b0, 32'h40, 3'd2, 32'h0, rd, resp, wt);
    chk("err_readback_40", rd, 32'h0BADF00D);

    // BUSY, IDLE and HREADY-low offers must start nothing.
    hsel = 1'b1; haddr = 32'h10; hwrite = 1'b0; htrans = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    htrans = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    force_nrdy = 1'b1; htrans = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    chk1("noaccept_hreadyout", ro_v[0], 1'b1);
    chk1("noaccept_hresp", resp_v[0], 1'b0);
    idle_bus();
    force_nrdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("noaccept_after_hreadyout", ro_v[0], 1'b1);

    // Three wait states with a pipelined second read held off until completion.
    active = 2'd1;
    xfer(1'b1, 32'h04, 3'd2, 32'h13572468, rd, resp, wt);
    chk("ws3_write_waits", wt, 3);
    xfer(1'b1, 32'h08, 3'd2, 32'h24681357, rd, resp, wt);
    two_xfers(1'b0, 32'h04, 32'h0, 1'b0, 32'h08, 32'h0, rd, wt, rd2, wt2);
    chk("ws3_read1_waits", wt, 3);
    chk("ws3_read1_data", rd, 32'h13572468);
    chk("ws3_read2_waits", wt2, 3);
    chk("ws3_read2_data", rd2, 32'h24681357);

    // Four wait states: reset during the second wait cycle abandons the write.
    active = 2'd2;
    xfer(1'b1, 32'h30, 3'd2, 32'hCAFEF00D, rd, resp, wt);
    chk("ws4_write_waits", wt, 4);
    addr_ph(1'b1, 32'h30, 3'd2);
    wait_ready("rst_addr", rd, resp, wt);
    idle_bus();
    hwdata = 32'h12345678;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk1("async_rst_hreadyout", ro_v[2], 1'b1);
    chk1("async_rst_hresp", resp_v[2], 1'b0);
    chk("async_rst_hrdata", rd_v[2], 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hwdata = 32'h0;
    @(posedge clk);
    #1;
    xfer(1'b0, 32'h30, 3'd2, 32'h0, rd, resp, wt);
    chk("rst_abandon_readback", rd, 32'hCAFEF00D);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
